// File: rtl/trap_sequencer_if.sv
// Fetch redirect channel between the trap sequencer and the fetch unit.
// A transfer happens on a clock edge where redirect_valid and redirect_ready are both high.
// redirect_valid and redirect_pc stay stable until that edge, and ready has no meaning while valid is low.
interface trap_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: picks one trap or mret per EX cycle by fixed priority,
// then sequences flush, the CSR commit strobe and the fetch redirect, and owns mstatus.MIE/MPIE.
module trap_sequencer #(
  parameter bit VECTOR_EN = 1'b1,
  parameter bit RESET_MIE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic               ins_mis_req,
  input  logic [31:0]        ins_mis_tgt,
  input  logic               ebreak_req,
  input  logic               ecall_req,
  input  logic               ld_mis_req,
  input  logic [31:0]        ld_mis_addr,
  input  logic               st_mis_req,
  input  logic [31:0]        st_mis_addr,
  input  logic               mret_req,
  input  logic               intr,
  input  logic [31:0]        mtvec,
  input  logic [31:0]        mepc,
  input  logic               mstatus_we,
  input  logic [31:0]        mstatus_wdat,
  output logic               stall_ex,
  output logic               flush,
  output logic               csr_we,
  output logic [31:0]        csr_mepc,
  output logic [31:0]        csr_mcause,
  output logic [31:0]        csr_mtval,
  trap_sequencer_if.master   redir,
  output logic               mstatus_mie,
  output logic               mstatus_mpie,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIR, RET} state_t;

  state_t      state, state_nxt;
  logic        take_intr, take_trap, take_mret;
  logic [31:0] sel_cause, sel_tval, trap_base, trap_target;
  logic [31:0] redir_pc_q;
  logic        unused_wdat;

  assign unused_wdat = ^{mstatus_wdat[31:8], mstatus_wdat[6:4], mstatus_wdat[2:0]};

  // Priority pick; only meaningful while IDLE, the caller gates with state.
  always_comb begin
    sel_cause = 32'd0;
    sel_tval  = 32'd0;
    take_intr = ex_valid & intr & mstatus_mie;
    take_trap = take_intr | (ex_valid & (ins_mis_req | ebreak_req | ecall_req |
                                         ld_mis_req | st_mis_req));
    take_mret = ex_valid & mret_req & ~take_trap;
    if (take_intr) begin
      sel_cause = 32'h8000_000B;
    end else if (ins_mis_req) begin
      sel_cause = 32'd0;
      sel_tval  = ins_mis_tgt;
    end else if (ebreak_req) begin
      sel_cause = 32'd3;
    end else if (ecall_req) begin
      sel_cause = 32'd11;
    end else if (ld_mis_req) begin
      sel_cause = 32'd4;
      sel_tval  = ld_mis_addr;
    end else if (st_mis_req) begin
      sel_cause = 32'd6;
      sel_tval  = st_mis_addr;
    end
    trap_base   = {mtvec[31:2], 2'b00};
    trap_target = trap_base;
    if (VECTOR_EN && take_intr && (mtvec[1:0] == 2'b01)) begin
      trap_target = trap_base + {sel_cause[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    stall_ex             = 1'b0;
    flush                = 1'b0;
    csr_we               = 1'b0;
    redir.redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        if (take_trap)      state_nxt = COMMIT;
        else if (take_mret) state_nxt = RET;
      end
      COMMIT: begin
        stall_ex  = 1'b1;
        flush     = 1'b1;
        csr_we    = 1'b1;
        state_nxt = REDIR;
      end
      RET: begin
        stall_ex  = 1'b1;
        flush     = 1'b1;
        state_nxt = REDIR;
      end
      REDIR: begin
        stall_ex             = 1'b1;
        redir.redirect_valid = 1'b1;
        if (redir.redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Redirect target is frozen at the accept edge so it cannot move while waiting for ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_mepc     <= 32'd0;
      csr_mcause   <= 32'd0;
      csr_mtval    <= 32'd0;
      redir_pc_q   <= 32'd0;
      mstatus_mie  <= RESET_MIE;
      mstatus_mpie <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap) begin
            csr_mepc   <= ex_pc;
            csr_mcause <= sel_cause;
            csr_mtval  <= sel_tval;
            redir_pc_q <= trap_target;
          end else if (take_mret) begin
            redir_pc_q <= mepc;
          end else if (mstatus_we) begin
            mstatus_mie  <= mstatus_wdat[3];
            mstatus_mpie <= mstatus_wdat[7];
          end
        end
        COMMIT: begin
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
        end
        RET: begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign redir.redirect_pc = redir_pc_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed trap/mret/reset scenarios with literal checks,
// then randomized traffic compared every cycle against a cycle-count model of a trap.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 0, ins_mis_req = 0, ebreak_req = 0, ecall_req = 0;
  logic        ld_mis_req = 0, st_mis_req = 0, mret_req = 0, intr = 0, mstatus_we = 0;
  logic [31:0] ex_pc = 0, ins_mis_tgt = 0, ld_mis_addr = 0, st_mis_addr = 0;
  logic [31:0] mtvec = 0, mepc = 0, mstatus_wdat = 0;
  logic        stall_ex, flush, csr_we, mstatus_mie, mstatus_mpie;
  logic [31:0] csr_mepc, csr_mcause, csr_mtval;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  trap_sequencer_if rif ();

  trap_sequencer #(.VECTOR_EN(1'b1), .RESET_MIE(1'b0)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ins_mis_req(ins_mis_req), .ins_mis_tgt(ins_mis_tgt),
    .ebreak_req(ebreak_req), .ecall_req(ecall_req),
    .ld_mis_req(ld_mis_req), .ld_mis_addr(ld_mis_addr),
    .st_mis_req(st_mis_req), .st_mis_addr(st_mis_addr),
    .mret_req(mret_req), .intr(intr), .mtvec(mtvec), .mepc(mepc),
    .mstatus_we(mstatus_we), .mstatus_wdat(mstatus_wdat),
    .stall_ex(stall_ex), .flush(flush), .csr_we(csr_we),
    .csr_mepc(csr_mepc), .csr_mcause(csr_mcause), .csr_mtval(csr_mtval),
    .redir(rif.master), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a trap is "age" cycles old; 1 = flush cycle, >=2 = waiting on fetch.
  int          m_age;
  bit          m_ret, m_mie, m_mpie, m_found;
  logic [31:0] m_mepc, m_cause, m_tval, m_target;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_ret = 0; m_mie = 1'b0; m_mpie = 1'b0;
      m_mepc = 0; m_cause = 0; m_tval = 0; m_target = 0;
    end else if (m_age == 0) begin
      m_found = 1'b1;
      m_tval  = 0;
      if (ex_valid && intr && m_mie)   m_cause = 32'h8000000B;
      else if (ex_valid && ins_mis_req) begin m_cause = 0; m_tval = ins_mis_tgt; end
      else if (ex_valid && ebreak_req)  m_cause = 3;
      else if (ex_valid && ecall_req)   m_cause = 11;
      else if (ex_valid && ld_mis_req)  begin m_cause = 4; m_tval = ld_mis_addr; end
      else if (ex_valid && st_mis_req)  begin m_cause = 6; m_tval = st_mis_addr; end
      else m_found = 1'b0;
      if (m_found) begin
        m_age = 1; m_ret = 0; m_mepc = ex_pc;
        m_target = (mtvec / 4) * 4;
        if (m_cause == 32'h8000000B && mtvec % 4 == 1) m_target = m_target + 44;
      end else if (ex_valid && mret_req) begin
        m_age = 1; m_ret = 1; m_target = mepc;
      end else if (mstatus_we) begin
        m_mie = mstatus_wdat[3]; m_mpie = mstatus_wdat[7];
      end
    end else if (m_age == 1) begin
      if (m_ret) begin m_mie = m_mpie; m_mpie = 1'b1; end
      else       begin m_mpie = m_mie; m_mie = 1'b0; end
      m_age = 2;
    end else if (rif.redirect_ready) begin
      m_age = 0;
    end else begin
      m_age = m_age + 1;
    end
  end

  always @(negedge clk) begin
    chk("cmp_stall", {31'd0, stall_ex}, {31'd0, m_age != 0});
    chk("cmp_flush", {31'd0, flush}, {31'd0, m_age == 1});
    chk("cmp_csr_we", {31'd0, csr_we}, {31'd0, m_age == 1 && !m_ret});
    chk("cmp_rvalid", {31'd0, rif.redirect_valid}, {31'd0, m_age >= 2});
    chk("cmp_mie", {31'd0, mstatus_mie}, {31'd0, m_mie});
    chk("cmp_mpie", {31'd0, mstatus_mpie}, {31'd0, m_mpie});
    if (rst || (m_age == 1 && !m_ret)) begin
      chk("cmp_mepc", csr_mepc, m_mepc);
      chk("cmp_mcause", csr_mcause, m_cause);
      chk("cmp_mtval", csr_mtval, m_tval);
    end
    if (rst || m_age >= 2) chk("cmp_rpc", rif.redirect_pc, m_target);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_reqs();
    ins_mis_req = 0; ebreak_req = 0; ecall_req = 0; ld_mis_req = 0;
    st_mis_req = 0; mret_req = 0; intr = 0; mstatus_we = 0;
  endtask

  task automatic write_mstatus(input logic [31:0] v);
    mstatus_we = 1; mstatus_wdat = v;
    step();
    mstatus_we = 0;
  endtask

  task automatic drain();
    rif.redirect_ready = 1;
    for (int i = 0; i < 8 && stall_ex; i++) step();
    chk("drain_idle", {31'd0, stall_ex}, 32'd0);
    rif.redirect_ready = 0;
  endtask

  initial begin
    rif.redirect_ready = 0;
    repeat (2) step();
    chk("rst_stall", {31'd0, stall_ex}, 0);
    chk("rst_rvalid", {31'd0, rif.redirect_valid}, 0);
    chk("rst_mie", {31'd0, mstatus_mie}, 0);
    chk("rst_mcause", csr_mcause, 0);
    rst = 0;
    step();

    // ecall with MIE=1, then fetch holds off ready for three cycles
    write_mstatus(32'h08);
    ex_valid = 1; ex_pc = 32'h100; mtvec = 32'h200; ecall_req = 1;
    step();
    clear_reqs();
    chk("ecall_flush", {31'd0, flush}, 1);
    chk("ecall_we", {31'd0, csr_we}, 1);
    chk("ecall_mepc", csr_mepc, 32'h100);
    chk("ecall_cause", csr_mcause, 32'd11);
    chk("ecall_tval", csr_mtval, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rvalid", {31'd0, rif.redirect_valid}, 1);
      chk("hold_rpc", rif.redirect_pc, 32'h200);
      chk("hold_stall", {31'd0, stall_ex}, 1);
      chk("hold_flush", {31'd0, flush}, 0);
    end
    chk("ecall_mie", {31'd0, mstatus_mie}, 0);
    chk("ecall_mpie", {31'd0, mstatus_mpie}, 1);
    rif.redirect_ready = 1;
    step();
    rif.redirect_ready = 0;
    chk("ready_idle", {31'd0, rif.redirect_valid}, 0);
    chk("ready_stall", {31'd0, stall_ex}, 0);

    // load beats store
    ld_mis_req = 1; st_mis_req = 1; ld_mis_addr = 32'h1001; st_mis_addr = 32'h2002;
    step();
    clear_reqs();
    chk("ld_cause", csr_mcause, 32'd4);
    chk("ld_tval", csr_mtval, 32'h1001);
    drain();

    // vectored interrupt beats ecall; with MIE clear the ecall wins
    write_mstatus(32'h08);
    intr = 1; ecall_req = 1; mtvec = 32'h301;
    step();
    clear_reqs();
    chk("irq_cause", csr_mcause, 32'h8000000B);
    step();
    chk("irq_rpc", rif.redirect_pc, 32'h32C);
    drain();
    intr = 1; ecall_req = 1;
    step();
    clear_reqs();
    chk("masked_cause", csr_mcause, 32'd11);
    drain();

    // mret restores MIE from MPIE
    write_mstatus(32'h80);
    mepc = 32'h480; mret_req = 1;
    step();
    clear_reqs();
    chk("mret_flush", {31'd0, flush}, 1);
    chk("mret_we", {31'd0, csr_we}, 0);
    step();
    chk("mret_rpc", rif.redirect_pc, 32'h480);
    chk("mret_mie", {31'd0, mstatus_mie}, 1);
    chk("mret_mpie", {31'd0, mstatus_mpie}, 1);
    drain();

    // reset while waiting on fetch
    mtvec = 32'h200; ecall_req = 1;
    step();
    clear_reqs();
    step();
    rst = 1;
    #1;
    chk("abort_rvalid", {31'd0, rif.redirect_valid}, 0);
    chk("abort_stall", {31'd0, stall_ex}, 0);
    chk("abort_rpc", rif.redirect_pc, 0);
    chk("abort_mie", {31'd0, mstatus_mie}, 0);
    step();
    rst = 0;
    rif.redirect_ready = 1;
    repeat (3) begin
      step();
      chk("post_rst_rvalid", {31'd0, rif.redirect_valid}, 0);
    end
    rif.redirect_ready = 0;

    // randomized traffic, checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      ex_valid    = ($urandom_range(0, 9) != 0);
      ex_pc       = $urandom;
      ins_mis_req = ($urandom_range(0, 7) == 0);
      ins_mis_tgt = $urandom;
      ebreak_req  = ($urandom_range(0, 7) == 0);
      ecall_req   = ($urandom_range(0, 7) == 0);
      ld_mis_req  = ($urandom_range(0, 7) == 0);
      ld_mis_addr = $urandom;
      st_mis_req  = ($urandom_range(0, 7) == 0);
      st_mis_addr = $urandom;
      mret_req    = ($urandom_range(0, 5) == 0);
      intr        = ($urandom_range(0, 3) == 0);
      mtvec       = {$urandom_range(0, 32'h3FFF_FFFF), 2'(($urandom_range(0, 1)))};
      mepc        = $urandom;
      mstatus_we  = ($urandom_range(0, 3) == 0);
      mstatus_wdat = $urandom;
      rif.redirect_ready = ($urandom_range(0, 1) == 1);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    clear_reqs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
